// File: rtl/id_ex_operand_reg.sv
// ID->EX operand register: selects ALU operands and holds them in a main+skid buffer
// with valid/ready on both sides, synchronous flush and a saturating stall counter.
module id_ex_operand_reg #(
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned ALUOP_W = 4,
    parameter int unsigned CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_pc,
    input  logic [DATA_W-1:0]  in_rs1,
    input  logic [DATA_W-1:0]  in_rs2,
    input  logic [DATA_W-1:0]  in_imm,
    input  logic [1:0]         in_src1_sel,
    input  logic [1:0]         in_src2_sel,
    input  logic [ALUOP_W-1:0] in_alu_op,
    input  logic [4:0]         in_rd,
    input  logic               in_rd_wen,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  operator_1,
    output logic [DATA_W-1:0]  operator_2,
    output logic [ALUOP_W-1:0] alu_op,
    output logic [DATA_W-1:0]  out_pc,
    output logic [4:0]         out_rd,
    output logic               out_rd_wen,
    output logic [CNT_W-1:0]   stall_cnt
);

    localparam int unsigned RD_W = 5;

    typedef struct packed {
        logic [DATA_W-1:0]  op1;
        logic [DATA_W-1:0]  op2;
        logic [DATA_W-1:0]  pc;
        logic [ALUOP_W-1:0] alu_op;
        logic [RD_W-1:0]    rd;
        logic               rd_wen;
    } entry_t;

    entry_t            main_q, main_d;
    entry_t            skid_q, skid_d;
    entry_t            new_c;
    logic              main_v_q, main_v_d;
    logic              skid_v_q, skid_v_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic              acc_c;
    logic              drn_c;

    // Operand selection on the ID side; only the selected values are stored
    always_comb begin
        new_c        = '0;
        new_c.pc     = in_pc;
        new_c.alu_op = in_alu_op;
        new_c.rd     = in_rd;
        new_c.rd_wen = in_rd_wen;
        case (in_src1_sel)
            2'b00:   new_c.op1 = in_rs1;
            2'b01:   new_c.op1 = in_pc;
            default: new_c.op1 = '0;
        endcase
        case (in_src2_sel)
            2'b00:   new_c.op2 = in_rs2;
            2'b01:   new_c.op2 = in_imm;
            2'b10:   new_c.op2 = DATA_W'(3'd4);
            default: new_c.op2 = '0;
        endcase
    end

    assign acc_c = in_valid & ~skid_v_q;
    assign drn_c = main_v_q & out_ready;

    // Buffer next state; flush wins over everything, skid always drains ahead of new data
    always_comb begin
        main_d      = main_q;
        skid_d      = skid_q;
        main_v_d    = main_v_q;
        skid_v_d    = skid_v_q;
        stall_cnt_d = stall_cnt_q;

        if (flush) begin
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
        end else if (!main_v_q || drn_c) begin
            if (skid_v_q) begin
                main_d   = skid_q;
                main_v_d = 1'b1;
                skid_v_d = 1'b0;
            end else if (acc_c) begin
                main_d   = new_c;
                main_v_d = 1'b1;
            end else begin
                main_v_d = 1'b0;
            end
        end else if (acc_c) begin
            skid_d   = new_c;
            skid_v_d = 1'b1;
        end

        // Keep the stored write enable gated so out_rd_wen stays a plain flop output
        main_d.rd_wen = main_d.rd_wen & main_v_d;

        if (main_v_q && !out_ready && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q      <= '0;
            skid_q      <= '0;
            main_v_q    <= 1'b0;
            skid_v_q    <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            main_q      <= main_d;
            skid_q      <= skid_d;
            main_v_q    <= main_v_d;
            skid_v_q    <= skid_v_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign in_ready   = ~skid_v_q;
    assign out_valid  = main_v_q;
    assign operator_1 = main_q.op1;
    assign operator_2 = main_q.op2;
    assign alu_op     = main_q.alu_op;
    assign out_pc     = main_q.pc;
    assign out_rd     = main_q.rd;
    assign out_rd_wen = main_q.rd_wen;
    assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_operand_reg.sv
// Scoreboard bench for id_ex_operand_reg; a second instance with a 2-bit stall counter
// shares the stimulus to exercise counter saturation.
module tb_id_ex_operand_reg;

    localparam int unsigned DATA_W  = 64;
    localparam int unsigned ALUOP_W = 4;
    localparam int unsigned CNT_W   = 32;

    typedef struct {
        logic [63:0] op1;
        logic [63:0] op2;
        logic [63:0] pc;
        logic [3:0]  alu;
        logic [4:0]  rd;
        logic        wen;
    } exp_t;

    logic               clk;
    logic               rst_n;
    logic               flush;
    logic               in_valid;
    logic               in_ready;
    logic [DATA_W-1:0]  in_pc, in_rs1, in_rs2, in_imm;
    logic [1:0]         in_src1_sel, in_src2_sel;
    logic [ALUOP_W-1:0] in_alu_op;
    logic [4:0]         in_rd;
    logic               in_rd_wen;
    logic               out_valid;
    logic               out_ready;
    logic [DATA_W-1:0]  operator_1, operator_2, out_pc;
    logic [ALUOP_W-1:0] alu_op;
    logic [4:0]         out_rd;
    logic               out_rd_wen;
    logic [CNT_W-1:0]   stall_cnt;

    logic               s_in_ready, s_out_valid, s_out_rd_wen;
    logic [DATA_W-1:0]  s_op1, s_op2, s_pc;
    logic [ALUOP_W-1:0] s_alu_op;
    logic [4:0]         s_rd;
    logic [1:0]         s_stall_cnt;

    exp_t        sb[$];
    int          n_checks;
    int          n_fail;
    logic [31:0] stall_model;
    logic [1:0]  stall_model_s;

    id_ex_operand_reg #(.DATA_W(DATA_W), .ALUOP_W(ALUOP_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .in_src1_sel(in_src1_sel), .in_src2_sel(in_src2_sel),
        .in_alu_op(in_alu_op), .in_rd(in_rd), .in_rd_wen(in_rd_wen),
        .out_valid(out_valid), .out_ready(out_ready),
        .operator_1(operator_1), .operator_2(operator_2), .alu_op(alu_op),
        .out_pc(out_pc), .out_rd(out_rd), .out_rd_wen(out_rd_wen),
        .stall_cnt(stall_cnt)
    );

    id_ex_operand_reg #(.DATA_W(DATA_W), .ALUOP_W(ALUOP_W), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(s_in_ready),
        .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .in_src1_sel(in_src1_sel), .in_src2_sel(in_src2_sel),
        .in_alu_op(in_alu_op), .in_rd(in_rd), .in_rd_wen(in_rd_wen),
        .out_valid(s_out_valid), .out_ready(out_ready),
        .operator_1(s_op1), .operator_2(s_op2), .alu_op(s_alu_op),
        .out_pc(s_pc), .out_rd(s_rd), .out_rd_wen(s_out_rd_wen),
        .stall_cnt(s_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model_entry();
        exp_t e;
        case (in_src1_sel)
            2'b00:   e.op1 = in_rs1;
            2'b01:   e.op1 = in_pc;
            default: e.op1 = 64'd0;
        endcase
        case (in_src2_sel)
            2'b00:   e.op2 = in_rs2;
            2'b01:   e.op2 = in_imm;
            2'b10:   e.op2 = 64'd4;
            default: e.op2 = 64'd0;
        endcase
        e.pc  = in_pc;
        e.alu = in_alu_op;
        e.rd  = in_rd;
        e.wen = in_rd_wen;
        return e;
    endfunction

    task automatic rand_inputs();
        in_pc       = {$urandom, $urandom};
        in_rs1      = {$urandom, $urandom};
        in_rs2      = {$urandom, $urandom};
        in_imm      = {$urandom, $urandom};
        in_src1_sel = 2'($urandom_range(0, 3));
        in_src2_sel = 2'($urandom_range(0, 3));
        in_alu_op   = 4'($urandom_range(0, 15));
        in_rd       = 5'($urandom_range(0, 31));
        in_rd_wen   = 1'($urandom_range(0, 1));
    endtask

    // One clock: settle inputs, score the handshake at the coming edge, check at negedge
    task automatic tick();
        bit   acc, drn;
        exp_t e;
        #1;
        acc = in_valid && in_ready;
        drn = out_valid && out_ready;
        if (drn) begin
            if (sb.size() == 0) begin
                check("unexpected_output", 64'(out_valid), 64'd0);
            end else begin
                e = sb.pop_front();
                check("operator_1", operator_1, e.op1);
                check("operator_2", operator_2, e.op2);
                check("out_pc", out_pc, e.pc);
                check("alu_op", 64'(alu_op), 64'(e.alu));
                check("out_rd", 64'(out_rd), 64'(e.rd));
                check("out_rd_wen", 64'(out_rd_wen), 64'(e.wen));
            end
        end
        if (out_valid && !out_ready) begin
            if (stall_model != 32'hFFFF_FFFF) stall_model = stall_model + 32'd1;
            if (stall_model_s != 2'b11) stall_model_s = stall_model_s + 2'd1;
        end
        if (flush) sb.delete();
        else if (acc) sb.push_back(model_entry());
        @(negedge clk);
        check("out_valid", 64'(out_valid), 64'(sb.size() != 0));
        check("in_ready", 64'(in_ready), 64'(sb.size() < 2));
        if (!out_valid) check("rd_wen_gated", 64'(out_rd_wen), 64'd0);
        check("stall_cnt", 64'(stall_cnt), 64'(stall_model));
        check("stall_cnt_sat", 64'(s_stall_cnt), 64'(stall_model_s));
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        stall_model = '0;
        stall_model_s = '0;
        rst_n = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        rand_inputs();

        // Reset values
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_operator_1", operator_1, 64'd0);
        check("rst_operator_2", operator_2, 64'd0);
        check("rst_out_rd_wen", 64'(out_rd_wen), 64'd0);
        check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Operand select: pc and immediate
        out_ready   = 1'b1;
        in_valid    = 1'b1;
        in_src1_sel = 2'b01;
        in_src2_sel = 2'b01;
        in_pc       = 64'h0000_0000_8000_0000;
        in_imm      = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        in_valid = 1'b0;
        check("sel_operator_1", operator_1, 64'h0000_0000_8000_0000);
        check("sel_operator_2", operator_2, 64'hFFFF_FFFF_FFFF_FFFC);
        check("sel_out_valid", 64'(out_valid), 64'd1);
        tick();

        // Back-pressure: A then B fill main and skid, then drain in order
        out_ready = 1'b0;
        in_valid  = 1'b1;
        rand_inputs(); tick();
        rand_inputs(); tick();
        check("bp_in_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        repeat (4) tick();
        out_ready = 1'b1;
        tick();
        check("bp_drain_a_valid", 64'(out_valid), 64'd1);
        tick();
        check("bp_drain_b_empty", 64'(out_valid), 64'd0);

        // Streaming at full rate
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            rand_inputs();
            tick();
            check("stream_in_ready", 64'(in_ready), 64'd1);
            check("stream_out_valid", 64'(out_valid), 64'd1);
        end
        in_valid = 1'b0;
        tick();

        // Flush with both entries held and a new request pending
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_rd_wen = 1'b1;
        tick();
        in_rd_wen = 1'b1;
        tick();
        flush = 1'b1;
        rand_inputs();
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_in_ready", 64'(in_ready), 64'd1);
        check("flush_rd_wen", 64'(out_rd_wen), 64'd0);
        out_ready = 1'b1;
        repeat (2) tick();

        // Async reset between edges while entries are held
        out_ready = 1'b0;
        in_valid  = 1'b1;
        rand_inputs(); tick();
        rand_inputs(); tick();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_in_ready", 64'(in_ready), 64'd1);
        check("arst_stall_cnt", 64'(stall_cnt), 64'd0);
        check("arst_operator_1", operator_1, 64'd0);
        sb.delete();
        stall_model = '0;
        stall_model_s = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Randomised traffic with occasional flush
        for (int i = 0; i < 400; i++) begin
            rand_inputs();
            in_valid  = 1'($urandom_range(0, 99) < 70);
            out_ready = 1'($urandom_range(0, 99) < 60);
            flush     = 1'($urandom_range(0, 99) < 4);
            tick();
        end
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();
        check("final_empty", 64'(out_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
